// File: rtl/rect_fill_if.sv
// Command and framebuffer-write bundle for the rectangle filler.
interface rect_fill_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 16
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic signed [11:0]       cmd_x;
    logic signed [11:0]       cmd_y;
    logic        [9:0]        cmd_w;
    logic        [9:0]        cmd_h;
    logic        [DATA_W-1:0] cmd_color;
    logic                     fb_hold;
    logic                     fb_we;
    logic        [ADDR_W-1:0] fb_addr;
    logic        [DATA_W-1:0] fb_wdata;
    logic                     busy;
    logic                     done;
    logic        [ADDR_W-1:0] pix_count;

    // Command source / framebuffer sink side
    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_hold,
        input  cmd_ready, fb_we, fb_addr, fb_wdata, busy, done, pix_count
    );

    // Filler side
    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_hold,
        output cmd_ready, fb_we, fb_addr, fb_wdata, busy, done, pix_count
    );
endinterface

// File: rtl/rect_fill.sv
// Clipped solid-rectangle fill into a linear W x H framebuffer, one pixel per cycle.
module rect_fill #(
    parameter int unsigned W      = 320,
    parameter int unsigned H      = 240,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 16
) (
    input logic        clk_sys,
    input logic        rst_n,
    rect_fill_if.slave bus
);
    localparam int unsigned CW = 13;
    localparam logic signed [CW-1:0] W_S      = CW'(W);
    localparam logic signed [CW-1:0] H_S      = CW'(H);
    localparam logic [ADDR_W-1:0]    ROW_STEP = ADDR_W'(W);

    typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

    state_t state_q, state_d;

    logic signed [11:0]       x_q, x_d, y_q, y_d;
    logic        [9:0]        w_q, w_d, h_q, h_d;
    logic        [DATA_W-1:0] color_q, color_d;
    logic signed [CW-1:0]     xs_q, xs_d, xe_q, xe_d, ye_q, ye_d;
    logic signed [CW-1:0]     cx_q, cx_d, cy_q, cy_d;
    logic        [ADDR_W-1:0] row_q, row_d, pos_q, pos_d, cnt_q, cnt_d;
    logic                     fin_q, fin_d;
    logic                     ready_q, ready_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic        [ADDR_W-1:0] addr_q, addr_d, pix_q, pix_d;
    logic        [DATA_W-1:0] wdata_q, wdata_d;

    logic signed [CW-1:0]     x_ext, y_ext, w_ext, h_ext, sum_x, sum_y;
    logic signed [CW-1:0]     xs_c, xe_c, ys_c, ye_c;
    logic                     empty_c;
    logic        [ADDR_W-1:0] start_c;

    logic signed [CW-1:0]     cur_x, cur_y, cur_xs, cur_xe, cur_ye;
    logic        [ADDR_W-1:0] cur_row, cur_pos, cur_cnt;
    logic                     pending;

    // Clip the latched command against the screen in 13-bit signed arithmetic
    always_comb begin
        x_ext   = {x_q[11], x_q};
        y_ext   = {y_q[11], y_q};
        w_ext   = {3'b000, w_q};
        h_ext   = {3'b000, h_q};
        sum_x   = x_ext + w_ext;
        sum_y   = y_ext + h_ext;
        xs_c    = x_ext[CW-1] ? '0 : x_ext;
        ys_c    = y_ext[CW-1] ? '0 : y_ext;
        xe_c    = (sum_x > W_S) ? W_S : sum_x;
        ye_c    = (sum_y > H_S) ? H_S : sum_y;
        empty_c = (xs_c >= xe_c) || (ys_c >= ye_c);
        start_c = ADDR_W'($unsigned(ys_c)) * ROW_STEP + ADDR_W'($unsigned(xs_c));
    end

    // Current pending pixel: fresh from the clipper in CLIP, from registers in FILL
    always_comb begin
        cur_x   = (state_q == CLIP) ? xs_c    : cx_q;
        cur_y   = (state_q == CLIP) ? ys_c    : cy_q;
        cur_xs  = (state_q == CLIP) ? xs_c    : xs_q;
        cur_xe  = (state_q == CLIP) ? xe_c    : xe_q;
        cur_ye  = (state_q == CLIP) ? ye_c    : ye_q;
        cur_row = (state_q == CLIP) ? start_c : row_q;
        cur_pos = (state_q == CLIP) ? start_c : pos_q;
        cur_cnt = (state_q == CLIP) ? '0      : cnt_q;
        pending = ((state_q == CLIP) && !empty_c) || ((state_q == FILL) && !fin_q);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        color_d = color_q;
        xs_d    = xs_q;
        xe_d    = xe_q;
        ye_d    = ye_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        row_d   = row_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pix_d   = pix_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (bus.cmd_valid && ready_q) begin
                    x_d     = bus.cmd_x;
                    y_d     = bus.cmd_y;
                    w_d     = bus.cmd_w;
                    h_d     = bus.cmd_h;
                    color_d = bus.cmd_color;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = CLIP;
                end
            end
            CLIP: begin
                xs_d  = xs_c;
                xe_d  = xe_c;
                ye_d  = ye_c;
                cnt_d = '0;
                fin_d = 1'b0;
                if (empty_c) begin
                    done_d  = 1'b1;
                    pix_d   = '0;
                    state_d = DONE;
                end else begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (fin_q) begin
                    done_d  = 1'b1;
                    pix_d   = cnt_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Raster walk shared by CLIP exit and FILL; a hold freezes the pending pixel
        if (pending) begin
            cx_d  = cur_x;
            cy_d  = cur_y;
            row_d = cur_row;
            pos_d = cur_pos;
            cnt_d = cur_cnt;
            if (!bus.fb_hold) begin
                we_d    = 1'b1;
                addr_d  = cur_pos;
                wdata_d = color_q;
                cnt_d   = cur_cnt + ADDR_W'(1);
                if (cur_x + 13'sd1 == cur_xe) begin
                    if (cur_y + 13'sd1 == cur_ye) begin
                        fin_d = 1'b1;
                    end else begin
                        cx_d  = cur_xs;
                        cy_d  = cur_y + 13'sd1;
                        row_d = cur_row + ROW_STEP;
                        pos_d = cur_row + ROW_STEP;
                    end
                end else begin
                    cx_d  = cur_x + 13'sd1;
                    pos_d = cur_pos + ADDR_W'(1);
                end
            end
        end
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            xs_q    <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            row_q   <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            color_q <= color_d;
            xs_q    <= xs_d;
            xe_q    <= xe_d;
            ye_q    <= ye_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            row_q   <= row_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pix_q   <= pix_d;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.fb_we     = we_q;
    assign bus.fb_addr   = addr_q;
    assign bus.fb_wdata  = wdata_q;
    assign bus.done      = done_q;
    assign bus.pix_count = pix_q;

endmodule

// File: tb/tb_rect_fill.sv
// Randomized bench for rect_fill against a pixel-enumeration reference model.
module tb_rect_fill;
    localparam int unsigned W      = 320;
    localparam int unsigned H      = 240;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    rect_fill_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rect_fill #(.W(W), .H(H), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_sys (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with the expected one
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and check every write, the done pulse and the return to idle
    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [DATA_W-1:0] color, input int hold_mode,
                           input int abort_at);
        int exp_q[$];
        int n, cyc, holds, seen, done_cnt, done_cyc, wait_cnt;
        bit fin;

        for (int yy = y; yy < y + h; yy++)
            for (int xx = x; xx < x + w; xx++)
                if (xx >= 0 && xx < int'(W) && yy >= 0 && yy < int'(H))
                    exp_q.push_back(yy * int'(W) + xx);
        n = exp_q.size();

        wait_cnt = 0;
        while (!bus.cmd_ready && wait_cnt < 20) begin
            step();
            wait_cnt++;
        end
        check_eq("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);

        bus.cmd_valid = 1'b1;
        bus.cmd_x     = 12'(x);
        bus.cmd_y     = 12'(y);
        bus.cmd_w     = 10'(w);
        bus.cmd_h     = 10'(h);
        bus.cmd_color = color;
        bus.fb_hold   = 1'b0;
        step();

        cyc = 1; seen = 0; holds = 0; done_cnt = 0; done_cyc = 0; fin = 1'b0;
        check_eq("ready_drop", 32'(bus.cmd_ready), 32'd0);
        check_eq("busy_clip", 32'(bus.busy), 32'd1);

        while (!fin) begin
            if (bus.fb_we) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_write", 32'(seen + 1), 32'(n));
                end else begin
                    check_eq("addr", 32'(bus.fb_addr), 32'(exp_q.pop_front()));
                    check_eq("wdata", 32'(bus.fb_wdata), 32'(color));
                end
                seen++;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                check_eq("pix_count", 32'(bus.pix_count), 32'(n));
                fin = 1'b1;
            end
            if (abort_at > 0 && cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("abort_we", 32'(bus.fb_we), 32'd0);
                check_eq("abort_busy", 32'(bus.busy), 32'd0);
                check_eq("abort_ready", 32'(bus.cmd_ready), 32'd0);
                bus.cmd_valid = 1'b0;
                bus.fb_hold   = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    step();
                    check_eq("abort_no_done", 32'(bus.done), 32'd0);
                    check_eq("abort_no_we", 32'(bus.fb_we), 32'd0);
                end
                rst_n = 1'b1;
                step();
                check_eq("abort_ready_back", 32'(bus.cmd_ready), 32'd1);
                check_eq("abort_no_done_after", 32'(bus.done), 32'd0);
                return;
            end

            case (hold_mode)
                1:       bus.fb_hold = (cyc % 2 == 1);
                2:       bus.fb_hold = ($urandom_range(0, 3) == 0);
                default: bus.fb_hold = 1'b0;
            endcase
            if (bus.fb_hold && seen < n) holds++;

            // Garbage requests while busy must be ignored; stop before idle returns
            if (bus.done) begin
                bus.cmd_valid = 1'b0;
            end else begin
                bus.cmd_valid = 1'($urandom_range(0, 1));
                bus.cmd_x     = 12'($urandom);
                bus.cmd_y     = 12'($urandom);
                bus.cmd_w     = 10'($urandom);
                bus.cmd_h     = 10'($urandom);
                bus.cmd_color = DATA_W'($urandom);
            end

            if (!fin) begin
                if (cyc > n + holds + 20) begin
                    check_eq("timeout", 32'(cyc), 32'(n + holds + 2));
                    fin = 1'b1;
                end else begin
                    step();
                    cyc++;
                end
            end
        end

        bus.cmd_valid = 1'b0;
        bus.fb_hold   = 1'b0;
        check_eq("done_cycle", 32'(done_cyc), 32'(2 + n + holds));
        check_eq("done_count", 32'(done_cnt), 32'd1);
        check_eq("write_count", 32'(seen), 32'(n));
        step();
        check_eq("done_pulse_width", 32'(bus.done), 32'd0);
        check_eq("idle_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = '0;
        bus.fb_hold   = 1'b0;

        step();
        step();
        check_eq("rst_ready", 32'(bus.cmd_ready), 32'd0);
        check_eq("rst_we", 32'(bus.fb_we), 32'd0);
        check_eq("rst_addr", 32'(bus.fb_addr), 32'd0);
        check_eq("rst_wdata", 32'(bus.fb_wdata), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_pix", 32'(bus.pix_count), 32'd0);
        rst_n = 1'b1;
        step();
        check_eq("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

        run_cmd(0, 0, 320, 240, 16'h0F00, 0, 0);
        run_cmd(-5, -3, 10, 6, 16'h00F0, 0, 0);
        run_cmd(316, 238, 8, 8, 16'h000F, 0, 0);
        run_cmd(10, 10, 0, 5, 16'h0123, 0, 0);
        run_cmd(400, 10, 5, 5, 16'h0456, 0, 0);
        run_cmd(10, 10, 4, 4, 16'h0789, 1, 0);

        for (int k = 0; k < 12; k++) begin
            run_cmd(int'($urandom_range(0, 447)) - 64,
                    int'($urandom_range(0, 347)) - 64,
                    int'($urandom_range(0, 40)),
                    int'($urandom_range(0, 40)),
                    DATA_W'($urandom), int'($urandom_range(0, 2)), 0);
        end

        run_cmd(50, 50, 100, 100, 16'h0ABC, 0, 30);
        run_cmd(0, 0, 1, 1, 16'h0DEF, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rect_fill.md
RECT_FILL -- requirements
Module: rect_fill

Interface
REQ-001 Parameter W, default 320, framebuffer width in pixels.
REQ-002 Parameter H, default 240, framebuffer height in pixels.
REQ-003 Parameter ADDR_W, default 17, framebuffer address width.
REQ-004 Parameter DATA_W, default 16, pixel width; the lower 12 bits are RGB444.
REQ-005 clk_sys  in  1  system clock; the block is single-clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  block is idle and accepts a command.
REQ-009 cmd_x  in  12  signed left edge.
REQ-010 cmd_y  in  12  signed top edge.
REQ-011 cmd_w  in  10  unsigned width.
REQ-012 cmd_h  in  10  unsigned height.
REQ-013 cmd_color  in  DATA_W  fill value.
REQ-014 fb_hold  in  1  write stall, e.g. during a swap mask.
REQ-015 fb_we  out  1  framebuffer write strobe.
REQ-016 fb_addr  out  ADDR_W  write address.
REQ-017 fb_wdata  out  DATA_W  write data.
REQ-018 busy  out  1  a command is in progress.
REQ-019 done  out  1  single-cycle completion pulse.
REQ-020 pix_count  out  ADDR_W  pixels written by the last command.

Function
REQ-021 The state machine SHALL have the states IDLE, CLIP, FILL and DONE.
REQ-022 The command SHALL be accepted in IDLE on cmd_valid&cmd_ready at cycle N, and all cmd_* fields SHALL be latched at that edge.
REQ-023 cmd_ready SHALL be registered and high only in IDLE; it drops the cycle after acceptance.
REQ-024 CLIP (cycle N+1) SHALL compute the clipped bounds in 13-bit signed arithmetic:
- xs = max(x, 0); xe = min(x + w, W)
- ys = max(y, 0); ye = min(y + h, H)
- xe and ye are exclusive bounds.
REQ-025 If xs >= xe or ys >= ye, CLIP SHALL go directly to DONE with zero writes.
REQ-026 Otherwise, the first fb_we SHALL be asserted at cycle N+2 with fb_addr = ys*W + xs.
REQ-027 FILL SHALL write in raster order: x increments left to right, then the row advances and x returns to xs.
REQ-028 The row base address SHALL be maintained incrementally (+W per row); no multiplier is used.
REQ-029 FILL SHALL issue one write per cycle while fb_hold=0.
REQ-030 While fb_hold=1, fb_we SHALL be 0 and the position and address SHALL hold; no pixel is skipped or duplicated.
REQ-031 fb_wdata SHALL equal the latched cmd_color on every write.
REQ-032 After the write to (xe-1, ye-1), the FSM SHALL enter DONE.
REQ-033 In DONE, done SHALL be high for exactly one cycle and pix_count SHALL update to (xe-xs)*(ye-ys), or to 0 for an empty command.
REQ-034 The FSM SHALL return to IDLE the cycle after DONE.
REQ-035 busy SHALL be high in CLIP, FILL and DONE.
REQ-036 cmd_valid outside IDLE SHALL be ignored; commands are never queued.
REQ-037 fb_we, fb_addr and fb_wdata SHALL be registered outputs.
REQ-038 fb_addr SHALL never exceed W*H-1.

Reset
REQ-039 On rst_n low, the block SHALL asynchronously go to IDLE with cmd_ready=0, fb_we=0, fb_addr=0, fb_wdata=0, busy=0, done=0 and pix_count=0.
REQ-040 On the first clk_sys edge after rst_n rises, cmd_ready SHALL become 1.
REQ-041 Reset during FILL SHALL abort the command immediately: no further writes and no done pulse.

Verification
REQ-042 Full screen: x=0, y=0, w=320, h=240, color 0x0F00 -> 76800 writes at consecutive addresses 0..76799; done once at N+2+76800; pix_count=76800.
REQ-043 Top-left clip: x=-5, y=-3, w=10, h=6 -> 15 writes at addresses 0-4, 320-324 and 640-644; pix_count=15.
REQ-044 Bottom-right clip: x=316, y=238, w=8, h=8 -> 8 writes at addresses 76476-76479 and 76796-76799.
REQ-045 Empty command: w=0, or x=400 -> no fb_we; done at N+2; pix_count=0.
REQ-046 Stall: a 4x4 fill at (10, 10) with fb_hold toggling every cycle -> exactly 16 unique writes in raster order; done delayed by the number of hold cycles.
REQ-047 Reset mid-fill: rst_n pulsed low during FILL of a 100x100 rectangle -> fb_we=0 and busy=0 immediately with no done; a subsequent 1x1 command at (0, 0) writes address 0 once.
